// File: rtl/cdb_pkg.sv
// Purpose: shared CDB types and helpers for the execute/writeback path.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package cdb_pkg;

  localparam int FLAG_W = 4;

  // Same bit order as the ALU flag output, so slices can be cast directly.
  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
    logic negative;
  } cdb_flags_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } cdb_state_e;

  // ROB tag width: one extra code point beyond the entry count.
  function automatic int rob_tag_w(input int rob_size);
    return $clog2(rob_size + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter, request scan starts at ptr_i and wraps.
// Latency: purely combinational, zero cycles.
// Backpressure: en_i low forces gnt_o to zero; no state is kept.
// Ports: req_i request vector, ptr_i highest-priority index, en_i grant enable,
//        gnt_o one-hot grant, winner_o index of the winner (valid when any_o),
//        any_o a grant is issued this cycle.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  logic [2*N-1:0] dbl_req;
  logic           found;
  logic [W-1:0]   win_idx;

  // Doubling the request vector turns the wrapping scan into a linear one:
  // positions below ptr_i in the lower copy are skipped and reappear in the
  // upper copy, which gives them the lowest priority.
  always_comb begin
    dbl_req = {req_i, req_i};
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl_req[i] && (i >= int'(ptr_i))) begin
        found   = 1'b1;
        win_idx = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      if (en_i && found && (win_idx == W'(k))) gnt_o[k] = 1'b1;
    end
  end

  assign winner_o = win_idx;
  assign any_o    = en_i & found;

endmodule

// File: rtl/exec_decision_unit.sv
// Purpose: arbitrates the common data bus among execute stages and registers
//          the winning result for the ROB write port and RS wakeup.
// Latency: canGo_o is combinational; the broadcast appears one cycle after grant.
// Backpressure: robStall_i holds a full CDB register and suppresses new grants;
//               flush_i suppresses grants and empties the register.
// Ports: unit* packed per-stage results (slice k = stage k), canGo_o one-hot
//        grant back to the stages, cdb* registered broadcast.
module exec_decision_unit
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = rob_tag_w(ROBsize),
  parameter int UNIT_W     = $clog2(NUM_UNITS)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_UNITS-1:0]            unitValid_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
  input  logic [NUM_UNITS*64-1:0]         unitVal_i,
  input  logic [NUM_UNITS*FLAG_W-1:0]     unitFlags_i,
  output logic [NUM_UNITS-1:0]            canGo_o,
  input  logic                            robStall_i,
  input  logic                            flush_i,
  output logic                            cdbValid_o,
  output logic [ROBsizeLog-1:0]           cdbTag_o,
  output logic [63:0]                     cdbVal_o,
  output logic [FLAG_W-1:0]               cdbFlags_o,
  output logic [UNIT_W-1:0]               cdbUnit_o
);

  cdb_state_e            state_q;
  logic [ROBsizeLog-1:0] cdb_tag_q;
  logic [63:0]           cdb_val_q;
  cdb_flags_t            cdb_flags_q;
  logic [UNIT_W-1:0]     cdb_unit_q;
  logic [UNIT_W-1:0]     ptr_q, ptr_d;

  logic                  grant_en, grant_any;
  logic [NUM_UNITS-1:0]  gnt;
  logic [UNIT_W-1:0]     winner;
  logic [ROBsizeLog-1:0] win_tag;
  logic [63:0]           win_val;
  cdb_flags_t            win_flags;

  // Grant only when the register is empty or draining this cycle; reset_i is
  // included so no stage is released while the unit is held in reset.
  assign grant_en = reset_i & ~flush_i & ((state_q == IDLE) | ~robStall_i);

  rr_arbiter #(
    .N (NUM_UNITS),
    .W (UNIT_W)
  ) u_arb (
    .req_i    (unitValid_i),
    .ptr_i    (ptr_q),
    .en_i     (grant_en),
    .gnt_o    (gnt),
    .winner_o (winner),
    .any_o    (grant_any)
  );

  assign canGo_o = gnt;

  // Explicit wrap so non-power-of-two unit counts never index a missing unit.
  assign ptr_d = (winner == UNIT_W'(NUM_UNITS - 1)) ? '0 : winner + UNIT_W'(1);

  // One-hot mux of the winner's payload, driven by the grant vector.
  always_comb begin
    win_tag   = '0;
    win_val   = '0;
    win_flags = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (gnt[k]) begin
        win_tag   = unitTag_i[k*ROBsizeLog +: ROBsizeLog];
        win_val   = unitVal_i[k*64 +: 64];
        win_flags = cdb_flags_t'(unitFlags_i[k*FLAG_W +: FLAG_W]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      cdb_flags_q <= '0;
      cdb_unit_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else if (grant_any) begin
      state_q     <= BCAST;
      ptr_q       <= ptr_d;
      cdb_tag_q   <= win_tag;
      cdb_val_q   <= win_val;
      cdb_flags_q <= win_flags;
      cdb_unit_q  <= winner;
    end else if (!robStall_i) begin
      // Consumed by the ROB with nothing to replace it.
      state_q <= IDLE;
    end
  end

  assign cdbValid_o = (state_q == BCAST);
  assign cdbTag_o   = cdb_tag_q;
  assign cdbVal_o   = cdb_val_q;
  assign cdbFlags_o = cdb_flags_q;
  assign cdbUnit_o  = cdb_unit_q;

endmodule

// File: tb/tb_exec_decision_unit.sv
// Purpose: self-checking bench for exec_decision_unit (4-unit and 3-unit builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_exec_decision_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-unit instance
  logic [3:0]   v4, cg4, cf4, ct4;
  logic [15:0]  tag4, fl4;
  logic [255:0] val4;
  logic         stall4, flush4, cv4;
  logic [63:0]  cval4;
  logic [1:0]   cu4;

  // 3-unit instance
  logic [2:0]   v3, cg3;
  logic [11:0]  tag3, fl3;
  logic [191:0] val3;
  logic         stall3, flush3, cv3;
  logic [3:0]   ct3, cf3;
  logic [63:0]  cval3;
  logic [1:0]   cu3;

  exec_decision_unit #(.NUM_UNITS(4), .ROBsize(8)) dut4 (
    .clk_i(clk), .reset_i(rst_n), .unitValid_i(v4), .unitTag_i(tag4),
    .unitVal_i(val4), .unitFlags_i(fl4), .canGo_o(cg4), .robStall_i(stall4),
    .flush_i(flush4), .cdbValid_o(cv4), .cdbTag_o(ct4), .cdbVal_o(cval4),
    .cdbFlags_o(cf4), .cdbUnit_o(cu4));

  exec_decision_unit #(.NUM_UNITS(3), .ROBsize(8)) dut3 (
    .clk_i(clk), .reset_i(rst_n), .unitValid_i(v3), .unitTag_i(tag3),
    .unitVal_i(val3), .unitFlags_i(fl3), .canGo_o(cg3), .robStall_i(stall3),
    .flush_i(flush3), .cdbValid_o(cv3), .cdbTag_o(ct3), .cdbVal_o(cval3),
    .cdbFlags_o(cf3), .cdbUnit_o(cu3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a broadcast register plus a priority pointer per instance.
  int          m_ptr[2];
  logic        m_v[2];
  logic [3:0]  m_tag[2];
  logic [63:0] m_val[2];
  logic [3:0]  m_fl[2];
  int          m_unit[2];

  function automatic int pick(input logic [7:0] req, input int ptr, input int n);
    for (int j = 0; j < n; j++) begin
      if (req[(ptr + j) % n]) return (ptr + j) % n;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_v[d] = 1'b0; m_tag[d] = '0; m_val[d] = '0; m_fl[d] = '0; m_unit[d] = 0;
    end
  endtask

  // Winner for this cycle, or -1 when nothing may be granted.
  function automatic int predict(input int d, input int n, input logic [7:0] req,
                                 input logic stall, input logic flush);
    if (flush || (m_v[d] && stall)) return -1;
    return pick(req, m_ptr[d], n);
  endfunction

  task automatic advance(input int d, input int n, input int w, input logic stall,
                         input logic flush, input logic [3:0] tg, input logic [63:0] vl,
                         input logic [3:0] fl);
    if (flush) begin
      m_v[d] = 1'b0; m_ptr[d] = 0;
    end else if (w >= 0) begin
      m_v[d] = 1'b1; m_tag[d] = tg; m_val[d] = vl; m_fl[d] = fl; m_unit[d] = w;
      m_ptr[d] = (w + 1) % n;
    end else if (!stall) begin
      m_v[d] = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       stall;
    logic       flush;
    logic [3:0] cango;
    logic       pre_v;
    int         pre_u;
  } vec_t;
  vec_t tbl[20];

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    v4 = '0; stall4 = 1'b0; flush4 = 1'b0;
    v3 = '0; stall3 = 1'b0; flush3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [63:0] eg;
    int w;

    // Fixed per-unit payload: tag k+1, value 16+k, flags k^2 (unit 2: tag 3, val 18, flags 0).
    for (int k = 0; k < 4; k++) begin
      tag4[k*4 +: 4]   = 4'(k + 1);
      val4[k*64 +: 64] = 64'(16 + k);
      fl4[k*4 +: 4]    = 4'(k ^ 2);
    end
    tag3 = '0; val3 = '0; fl3 = '0;
    v3 = '0; stall3 = 1'b0; flush3 = 1'b0;
    stall4 = 1'b0; flush4 = 1'b0;
    model_clear();

    //              valid    st   fl   canGo    preV  preU
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 1};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 3};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 0};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 1};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 3};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2};
    tbl[11] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2};
    tbl[12] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2};
    tbl[13] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2};
    tbl[14] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2};
    tbl[15] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, 1};
    tbl[16] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 0};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0};

    // Reset held two cycles with every unit requesting.
    rst_n = 1'b0;
    v4 = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_cango", 64'(cg4), 64'd0);
    chk("rst_valid", 64'(cv4), 64'd0);
    chk("rst_tag",   64'(ct4), 64'd0);
    chk("rst_val",   cval4,    64'd0);
    chk("rst_flags", 64'(cf4), 64'd0);
    chk("rst_unit",  64'(cu4), 64'd0);

    // Directed table; reset is released at the start of row 0.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rst_n  = 1'b1;
      v4     = tbl[i].valid;
      stall4 = tbl[i].stall;
      flush4 = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("row%0d_cango", i), 64'(cg4), 64'(tbl[i].cango));
      chk($sformatf("row%0d_valid", i), 64'(cv4), 64'(tbl[i].pre_v));
      if (tbl[i].pre_v) begin
        chk($sformatf("row%0d_unit", i),  64'(cu4), 64'(tbl[i].pre_u));
        chk($sformatf("row%0d_tag", i),   64'(ct4), 64'(tbl[i].pre_u + 1));
        chk($sformatf("row%0d_val", i),   cval4,    64'(16 + tbl[i].pre_u));
        chk($sformatf("row%0d_flags", i), 64'(cf4), 64'(tbl[i].pre_u ^ 2));
      end
    end

    // Three-unit build: pointer must wrap from 2 back to 0.
    do_reset();
    v3 = 3'b100;
    @(negedge clk);
    chk("w3_first_cango", 64'(cg3), 64'b100);
    @(posedge clk); #1;
    v3 = 3'b101;
    @(negedge clk);
    chk("w3_wrap_cango", 64'(cg3), 64'b001);
    chk("w3_wrap_unit",  64'(cu3), 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w3_next_cango", 64'(cg3), 64'b100);
    chk("w3_next_unit",  64'(cu3), 64'd0);

    // Randomized run of both builds against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      v4 = 4'($urandom); stall4 = ($urandom_range(0, 3) == 0); flush4 = ($urandom_range(0, 15) == 0);
      v3 = 3'($urandom); stall3 = ($urandom_range(0, 3) == 0); flush3 = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 4; k++) begin
        tag4[k*4 +: 4] = 4'($urandom); val4[k*64 +: 64] = {$urandom, $urandom}; fl4[k*4 +: 4] = 4'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
        tag3[k*4 +: 4] = 4'($urandom); val3[k*64 +: 64] = {$urandom, $urandom}; fl3[k*4 +: 4] = 4'($urandom);
      end
      @(negedge clk);

      w = predict(0, 4, 8'(v4), stall4, flush4);
      eg = '0; if (w >= 0) eg[w] = 1'b1;
      chk("rnd4_cango", 64'(cg4), eg);
      chk("rnd4_valid", 64'(cv4), 64'(m_v[0]));
      if (m_v[0]) begin
        chk("rnd4_tag", 64'(ct4), 64'(m_tag[0]));
        chk("rnd4_val", cval4, m_val[0]);
        chk("rnd4_flags", 64'(cf4), 64'(m_fl[0]));
        chk("rnd4_unit", 64'(cu4), 64'(m_unit[0]));
      end
      if (w >= 0) advance(0, 4, w, stall4, flush4, tag4[w*4 +: 4], val4[w*64 +: 64], fl4[w*4 +: 4]);
      else        advance(0, 4, w, stall4, flush4, '0, '0, '0);

      w = predict(1, 3, 8'(v3), stall3, flush3);
      eg = '0; if (w >= 0) eg[w] = 1'b1;
      chk("rnd3_cango", 64'(cg3), eg);
      chk("rnd3_valid", 64'(cv3), 64'(m_v[1]));
      if (m_v[1]) begin
        chk("rnd3_tag", 64'(ct3), 64'(m_tag[1]));
        chk("rnd3_val", cval3, m_val[1]);
        chk("rnd3_flags", 64'(cf3), 64'(m_fl[1]));
        chk("rnd3_unit", 64'(cu3), 64'(m_unit[1]));
      end
      if (w >= 0) advance(1, 3, w, stall3, flush3, tag3[w*4 +: 4], val3[w*64 +: 64], fl3[w*4 +: 4]);
      else        advance(1, 3, w, stall3, flush3, '0, '0, '0);
    end

    // Reset asserted mid-broadcast clears outputs without waiting for a clock.
    @(posedge clk); #1;
    v4 = 4'b1111; stall4 = 1'b0; flush4 = 1'b0;
    for (int k = 0; k < 4; k++) val4[k*64 +: 64] = 64'hFFFF_0000_0000_0001;
    @(posedge clk); #1;
    chk("midrst_pre_valid", 64'(cv4), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(cv4), 64'd0);
    chk("midrst_cango", 64'(cg4), 64'd0);
    chk("midrst_val",   cval4,    64'd0);
    chk("midrst_tag",   64'(ct4), 64'd0);
    chk("midrst_unit",  64'(cu4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_decision_unit.md
Name: exec_decision_unit

Overview:
- Execution decision unit. Arbitrates the single common data bus (CDB) among NUM_UNITS execute stages (ALU, multiply, load, ...).
- Each execute stage holds its result with valid_o high until it receives canGo.
- Grant policy is round-robin. The winner's tag, value and flags are captured into a one-entry CDB output register that feeds the ROB and the reservation-station wakeup.
- Sits between the execute stages and the ROB write port.

Parameters:
- NUM_UNITS, 4, number of execute stages competing for the CDB (2..8).
- ROBsize, 8, ROB entry count.
- ROBsizeLog, $clog2(ROBsize+1), tag width.
- UNIT_W, $clog2(NUM_UNITS), width of the unit index.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- unitValid_i  in  NUM_UNITS  bit k = stage k holds a finished result.
- unitTag_i  in  NUM_UNITS*ROBsizeLog  packed tags; unit k at slice k.
- unitVal_i  in  NUM_UNITS*64  packed 64-bit results.
- unitFlags_i  in  NUM_UNITS*4  packed flags {carry_out, overflow, zero, negative}.
- canGo_o  out  NUM_UNITS  one-hot grant, combinational; all-zero when no grant.
- robStall_i  in  1  ROB cannot accept a CDB write this cycle.
- flush_i  in  1  synchronous mispredict flush.
- cdbValid_o  out  1  CDB register holds a valid broadcast.
- cdbTag_o  out  ROBsizeLog  broadcast tag.
- cdbVal_o  out  64  broadcast value.
- cdbFlags_o  out  4  broadcast flags.
- cdbUnit_o  out  UNIT_W  index of the unit that produced the broadcast.

Behaviour:
- Reset (reset_i low, asynchronous):
  - cdbValid_o=0; cdbTag_o, cdbVal_o, cdbFlags_o, cdbUnit_o = 0.
  - Priority pointer ptr_r = 0; pipeline state = IDLE.
- State machine, 2 states keyed on cdbValid_o:
  - IDLE: CDB register empty.
  - BCAST: CDB register holds a broadcast.
  - The register is consumed every cycle robStall_i is low.
  - BCAST with robStall_i high holds all cdb* outputs stable.
- Grant enable: grantEn = ~flush_i & (~cdbValid_o | ~robStall_i). The register is empty or draining this cycle.
- Round-robin search: scan units ptr_r, ptr_r+1, ..., wrapping modulo NUM_UNITS. The first k with unitValid_i[k]=1 wins.
- canGo_o[k] = grantEn & win[k]. At most one bit is set. Fully combinational, zero-cycle latency from unitValid_i.
- On a grant edge:
  - The CDB register loads the winner's tag, value, flags and index; cdbValid_o=1 next cycle.
  - ptr_r <= winner+1, wrapping to 0 after NUM_UNITS-1.
- No grant, register draining (robStall_i=0): cdbValid_o <= 0. ptr_r is unchanged.
- No grant, robStall_i=1, register full: hold all outputs.
- Latency: unitValid_i high and granted in cycle N gives the broadcast visible in cycle N+1. Back-to-back grants every cycle are allowed, so throughput is 1 result per cycle.
- flush_i=1:
  - canGo_o = 0.
  - cdbValid_o <= 0 next edge, regardless of robStall_i.
  - ptr_r <= 0.
  - Execute stages hold their data; the stages themselves are flushed by their own logic.
- Fairness: a unit with valid held high is granted within NUM_UNITS grant cycles.
- NUM_UNITS not a power of two: pointer wrap is explicit (compare to NUM_UNITS-1), never a natural overflow.
- Reset asserted mid-broadcast: outputs clear immediately (asynchronous). No canGo is issued while reset_i is low.
- unitValid_i bits of units not granted are ignored that cycle; no request state is stored internally.

Decomposition:
- Shared package cdb_pkg:
  - cdb_flags_t, a 4-bit struct ordered {carry_out, overflow, zero, negative}, matching the ALU flag order.
  - Localparam FLAG_W=4.
  - Function for ROB tag width from ROBsize.
- Sub-module rr_arbiter (NUM_UNITS): inputs req, ptr, en; output one-hot gnt and winner index.
  - Purely combinational, implemented as a doubled-request priority scan.
  - Reused later by the reservation-station issue select.

Test Plan:
- Reset: hold reset_i low 2 cycles with all unitValid_i=1 -> canGo_o=0, cdbValid_o=0, all cdb* outputs 0. Release reset -> next cycle canGo_o=4'b0001.
- Single request: unit 2 valid, tag=3, val=64'd18, flags=4'b0000 -> canGo_o=4'b0100 same cycle. Next cycle cdbValid_o=1, cdbTag_o=3, cdbVal_o=18, cdbUnit_o=2.
- Round-robin: unitValid_i=4'b1111 held 8 cycles -> grant sequence 0,1,2,3,0,1,2,3 and cdbValid_o=1 continuously.
- ROB stall: full register, robStall_i=1 for 3 cycles with unit 1 requesting -> canGo_o=0 and cdb* outputs unchanged. robStall_i drops -> unit 1 is granted that cycle and broadcast the next.
- Pointer wrap with NUM_UNITS=3: grant unit 2, then units 0 and 2 request -> unit 0 wins.
- Flush: full register plus unit 3 requesting, assert flush_i -> canGo_o=0. Next cycle cdbValid_o=0 and ptr_r=0, so the next grant with all units requesting goes to unit 0.
